// File: rtl/muldiv_hilo_unit_if.sv
// Issue-side bundle for the shared mul/div/HI-LO unit.
// master: EX-stage issue logic; slave: muldiv_hilo_unit.
interface muldiv_hilo_unit_if #(
  parameter int XLEN    = 32,
  parameter int ISSUE_W = 2
);
  logic [4*ISSUE_W-1:0]    req_op;
  logic [XLEN*ISSUE_W-1:0] src_a;
  logic [XLEN*ISSUE_W-1:0] src_b;
  logic [ISSUE_W-1:0]      flush;
  logic                    commit_kill;
  logic                    stall_o;
  logic                    done_o;
  logic [XLEN-1:0]         mul_lo_o;
  logic [XLEN-1:0]         hi_o;
  logic [XLEN-1:0]         lo_o;

  modport master (
    output req_op, src_a, src_b, flush, commit_kill,
    input  stall_o, done_o, mul_lo_o, hi_o, lo_o
  );

  modport slave (
    input  req_op, src_a, src_b, flush, commit_kill,
    output stall_o, done_o, mul_lo_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Shared multi-cycle multiply/divide engine with architectural HI/LO.
// One mul/div op is owned at a time (highest issuing slot wins); MTHI/MTLO
// write in the cycle they are presented.
// Optional macro MULDIV_EARLY_OUT_EN: divides by zero or with
// |dividend| < |divisor| finish the cycle after accept.
module muldiv_hilo_unit #(
  parameter int XLEN    = 32,
  parameter int ISSUE_W = 2,
  parameter int MUL_LAT = 3
) (
  input logic               clk,
  input logic               rst,
  muldiv_hilo_unit_if.slave bus
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MUL   = 4'd9,
    OP_MTHI  = 4'd10,
    OP_MTLO  = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  localparam int IW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int CW = $clog2(((XLEN > MUL_LAT) ? XLEN : MUL_LAT) + 1);

  function automatic logic [2*XLEN-1:0] mul_full(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic            sgn);
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    ea = {{XLEN{sgn & a[XLEN-1]}}, a};
    eb = {{XLEN{sgn & b[XLEN-1]}}, b};
    return ea * eb;
  endfunction

  state_e state_q, state_d;

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [3:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            sel_fire, sel_is_div, sel_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            early;

  logic [IW-1:0]   owner_q;
  logic [3:0]      kind_q;
  logic            signed_q, a_neg_q, q_neg_q, div0_q;
  logic [XLEN-1:0] opa_q, opb_q, rem_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] res_hi_q, res_lo_q, mul_lo_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            owner_flush;

  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] prod_run, prod_sel, hilo_new;
  logic              fsm_owns_hilo, fsm_wr;
  logic              mt_hi_en, mt_lo_en;
  logic [XLEN-1:0]   mt_hi_val, mt_lo_val;
  logic              stall, done;

  // Pick the owning slot: highest index carrying a mul/div op.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (bus.req_op[4*i +: 4] >= OP_MULT && bus.req_op[4*i +: 4] <= OP_MUL) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
        sel_op    = bus.req_op[4*i +: 4];
        sel_a     = bus.src_a[XLEN*i +: XLEN];
        sel_b     = bus.src_b[XLEN*i +: XLEN];
      end
    end
  end

  assign sel_fire    = sel_valid && !bus.flush[sel_idx];
  assign sel_is_div  = (sel_op == OP_DIV) || (sel_op == OP_DIVU);
  assign sel_signed  = (sel_op == OP_MULT) || (sel_op == OP_DIV) || (sel_op == OP_MADD) ||
                       (sel_op == OP_MSUB) || (sel_op == OP_MUL);
  assign abs_a       = (sel_signed && sel_a[XLEN-1]) ? -sel_a : sel_a;
  assign abs_b       = (sel_signed && sel_b[XLEN-1]) ? -sel_b : sel_b;
  assign owner_flush = bus.flush[owner_q];

`ifdef MULDIV_EARLY_OUT_EN
  assign early = sel_is_div && ((abs_b == '0) || (abs_a < abs_b));
`else
  assign early = 1'b0;
`endif

  assign prod_run  = mul_full(opa_q, opb_q, signed_q);
  assign prod_sel  = mul_full(sel_a, sel_b, sel_signed);
  assign div_shift = {rem_q, opa_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a flush of the owning slot abandons the op.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sel_fire) begin
          if (sel_is_div)        state_d = early ? S_DONE : S_DIV;
          else if (MUL_LAT == 1) state_d = S_DONE;
          else                   state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (owner_flush)             state_d = S_IDLE;
        else if (cnt_q == CW'(1))    state_d = S_DONE;
      end
      S_DIV: begin
        if (owner_flush)             state_d = S_IDLE;
        else if (cnt_q == CW'(1))    state_d = S_FIX;
      end
      S_FIX:   state_d = owner_flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; stall drops combinationally on an owner flush.
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE:              stall = sel_fire;
        S_MUL, S_DIV, S_FIX: stall = !owner_flush;
        S_DONE:              done  = 1'b1;
        default:             stall = 1'b0;
      endcase
    end
  end

  // Operand latch, multiply countdown and restoring-divide datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= '0;
      kind_q   <= '0;
      signed_q <= 1'b0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      mul_lo_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_fire) begin
            owner_q  <= sel_idx;
            kind_q   <= sel_op;
            signed_q <= sel_signed;
            a_neg_q  <= sel_signed & sel_a[XLEN-1];
            q_neg_q  <= sel_signed & (sel_a[XLEN-1] ^ sel_b[XLEN-1]);
            div0_q   <= (sel_b == '0);
            rem_q    <= '0;
            if (sel_is_div) begin
              opa_q <= abs_a;
              opb_q <= abs_b;
              cnt_q <= CW'(XLEN);
              if (early) begin
                res_lo_q <= (sel_b == '0) ? '1 : '0;
                res_hi_q <= sel_a;
              end
            end else begin
              opa_q <= sel_a;
              opb_q <= sel_b;
              cnt_q <= CW'(MUL_LAT - 1);
              if (MUL_LAT == 1) begin
                {res_hi_q, res_lo_q} <= prod_sel;
                if (sel_op == OP_MUL) mul_lo_q <= prod_sel[XLEN-1:0];
              end
            end
          end
        end
        S_MUL: begin
          if (!owner_flush) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              {res_hi_q, res_lo_q} <= prod_run;
              if (kind_q == OP_MUL) mul_lo_q <= prod_run[XLEN-1:0];
            end
          end
        end
        S_DIV: begin
          // opa_q shifts dividend bits out the top and quotient bits in the bottom.
          if (!owner_flush) begin
            cnt_q <= cnt_q - CW'(1);
            if (!div_diff[XLEN]) begin
              rem_q <= div_diff[XLEN-1:0];
              opa_q <= {opa_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= div_shift[XLEN-1:0];
              opa_q <= {opa_q[XLEN-2:0], 1'b0};
            end
          end
        end
        S_FIX: begin
          // Divide-by-zero leaves rem_q = |dividend|, so HI comes out as the dividend.
          res_lo_q <= div0_q ? '1 : (q_neg_q ? -opa_q : opa_q);
          res_hi_q <= a_neg_q ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

  assign fsm_owns_hilo = (state_q == S_DONE) && (kind_q != OP_MUL);
  assign fsm_wr        = fsm_owns_hilo && !bus.commit_kill;

  // New HI/LO value for the completing op; accumulate ops read HI/LO now.
  always_comb begin
    case (kind_q)
      OP_MADD, OP_MADDU: hilo_new = {hi_q, lo_q} + {res_hi_q, res_lo_q};
      OP_MSUB, OP_MSUBU: hilo_new = {hi_q, lo_q} - {res_hi_q, res_lo_q};
      default:           hilo_new = {res_hi_q, res_lo_q};
    endcase
  end

  // MTHI/MTLO writers; later (higher) slots override earlier ones.
  always_comb begin
    mt_hi_en  = 1'b0;
    mt_lo_en  = 1'b0;
    mt_hi_val = '0;
    mt_lo_val = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (!bus.flush[i]) begin
        if (bus.req_op[4*i +: 4] == OP_MTHI) begin
          mt_hi_en  = 1'b1;
          mt_hi_val = bus.src_a[XLEN*i +: XLEN];
        end
        if (bus.req_op[4*i +: 4] == OP_MTLO) begin
          mt_lo_en  = 1'b1;
          mt_lo_val = bus.src_a[XLEN*i +: XLEN];
        end
      end
    end
  end

  // Architectural HI/LO; the completing mul/div takes priority over MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fsm_wr) begin
      {hi_q, lo_q} <= hilo_new;
    end else if (!bus.commit_kill && !fsm_owns_hilo) begin
      if (mt_hi_en) hi_q <= mt_hi_val;
      if (mt_lo_en) lo_q <= mt_lo_val;
    end
  end

  assign bus.stall_o  = stall;
  assign bus.done_o   = done;
  assign bus.mul_lo_o = mul_lo_q;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit (XLEN=32, ISSUE_W=2, MUL_LAT=3).
module tb_muldiv_hilo_unit;
  localparam int XLEN    = 32;
  localparam int ISSUE_W = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = XLEN + 2;

  localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                         MADD = 4'd5, MADDU = 4'd6, MSUBU = 4'd8, MUL = 4'd9,
                         MTHI = 4'd10, MTLO = 4'd11;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.XLEN(XLEN), .ISSUE_W(ISSUE_W)) bus ();

  muldiv_hilo_unit #(.XLEN(XLEN), .ISSUE_W(ISSUE_W), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_op      = '0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.flush       = '0;
    bus.commit_kill = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[4*s +: 4]  = op;
    bus.src_a[32*s +: 32] = a;
    bus.src_b[32*s +: 32] = b;
  endtask

  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    idle_inputs();
    set_slot(0, MTHI, h, 32'h0);
    set_slot(1, MTLO, l, 32'h0);
    step();
    idle_inputs();
  endtask

  // Inputs already driven by caller; runs until done_o (bounded), then idles and steps the write edge.
  task automatic run_op(output int lat, output int stalls, output bit got_done, output logic [31:0] mlo);
    #1;
    lat      = 0;
    stalls   = bus.stall_o ? 1 : 0;
    got_done = 1'b0;
    mlo      = '0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      step();
      lat++;
      if (bus.done_o) begin
        got_done = 1'b1;
        mlo      = bus.mul_lo_o;
      end else if (bus.stall_o) begin
        stalls++;
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    rst = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    checks++; if (bus.mul_lo_o !== 32'h0) begin failures++; $display("FAIL reset_mul_lo got=%h exp=0", bus.mul_lo_o); end
    checks++; if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo_o); end
  endtask

  task automatic test_mult();
    int lat, stalls; bit got; logic [31:0] mlo;
    idle_inputs();
    set_slot(0, MULT, 32'hFFFFFFFD, 32'd7);
    run_op(lat, stalls, got, mlo);
    checks++; if (!got) begin failures++; $display("FAIL mult_done got=0 exp=1"); end
    checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL mult_latency got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (stalls != MUL_LAT) begin failures++; $display("FAIL mult_stalls got=%0d exp=%0d", stalls, MUL_LAT); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_lo got=%h exp=FFFFFFEB", bus.lo_o); end
  endtask

  task automatic test_select_mul();
    int lat, stalls; bit got; logic [31:0] mlo;
    idle_inputs();
    set_slot(0, MULTU, 32'd2, 32'd2);
    set_slot(1, MUL, 32'd6, 32'd7);
    run_op(lat, stalls, got, mlo);
    checks++; if (mlo !== 32'd42) begin failures++; $display("FAIL mul_gpr got=%h exp=%h", mlo, 32'd42); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL mul_hi_kept got=%h exp=FFFFFFFF", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_lo_kept got=%h exp=FFFFFFEB", bus.lo_o); end
  endtask

  task automatic test_div();
    int lat, stalls; bit got; logic [31:0] mlo;
    idle_inputs();
    set_slot(1, DIV, 32'hFFFFFFF9, 32'd2);
    run_op(lat, stalls, got, mlo);
    checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", lat, DIV_LAT); end
    checks++; if (stalls != DIV_LAT) begin failures++; $display("FAIL div_stalls got=%0d exp=%0d", stalls, DIV_LAT); end
    checks++; if (bus.lo_o !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_quot got=%h exp=FFFFFFFD", bus.lo_o); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_rem got=%h exp=FFFFFFFF", bus.hi_o); end

    idle_inputs();
    set_slot(0, DIVU, 32'd7, 32'd0);
    run_op(lat, stalls, got, mlo);
    checks++; if (bus.lo_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_quot got=%h exp=FFFFFFFF", bus.lo_o); end
    checks++; if (bus.hi_o !== 32'd7) begin failures++; $display("FAIL divu0_rem got=%h exp=00000007", bus.hi_o); end

    idle_inputs();
    set_slot(0, DIV, 32'hFFFFFFFB, 32'd0);
    run_op(lat, stalls, got, mlo);
    checks++; if (bus.lo_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0s_quot got=%h exp=FFFFFFFF", bus.lo_o); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFB) begin failures++; $display("FAIL div0s_rem got=%h exp=FFFFFFFB", bus.hi_o); end

    idle_inputs();
    set_slot(1, DIV, 32'h80000000, 32'hFFFFFFFF);
    run_op(lat, stalls, got, mlo);
    checks++; if (bus.lo_o !== 32'h80000000) begin failures++; $display("FAIL divmin_quot got=%h exp=80000000", bus.lo_o); end
    checks++; if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL divmin_rem got=%h exp=00000000", bus.hi_o); end
  endtask

  task automatic test_accumulate();
    int lat, stalls; bit got; logic [31:0] mlo;
    load_hilo(32'h0, 32'h10);
    set_slot(0, MSUBU, 32'd3, 32'd5);
    run_op(lat, stalls, got, mlo);
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h1) begin failures++; $display("FAIL msubu got=%h exp=%h", {bus.hi_o, bus.lo_o}, 64'h1); end

    load_hilo(32'h0, 32'hFFFFFFFF);
    set_slot(1, MADD, 32'd1, 32'd1);
    run_op(lat, stalls, got, mlo);
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h1_00000000) begin failures++; $display("FAIL madd got=%h exp=%h", {bus.hi_o, bus.lo_o}, 64'h1_00000000); end

    load_hilo(32'h0, 32'h0);
    set_slot(0, MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(lat, stalls, got, mlo);
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'hFFFFFFFE_00000001) begin failures++; $display("FAIL maddu got=%h exp=%h", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFE_00000001); end
  endtask

  task automatic test_flush();
    bit done_seen;
    int stall_hi;
    load_hilo(32'h1234, 32'h5678);
    set_slot(1, DIVU, 32'd100, 32'd3);
    stall_hi = 0;
    repeat (5) begin
      step();
      if (bus.stall_o) stall_hi++;
    end
    checks++; if (stall_hi != 5) begin failures++; $display("FAIL flush_prestall got=%0d exp=5", stall_hi); end
    bus.flush[1] = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall_drop got=%b exp=0", bus.stall_o); end
    step();
    idle_inputs();
    done_seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.done_o) done_seen = 1'b1;
    end
    checks++; if (done_seen) begin failures++; $display("FAIL flush_no_done got=1 exp=0"); end
    checks++; if (bus.hi_o !== 32'h1234 || bus.lo_o !== 32'h5678) begin
      failures++; $display("FAIL flush_hilo got=%h:%h exp=00001234:00005678", bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_mthilo();
    idle_inputs();
    set_slot(0, MTHI, 32'hAA, 32'h0);
    set_slot(1, MTLO, 32'hBB, 32'h0);
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL mt_nostall got=%b exp=0", bus.stall_o); end
    step();
    idle_inputs();
    checks++; if (bus.hi_o !== 32'hAA || bus.lo_o !== 32'hBB) begin
      failures++; $display("FAIL mt_pair got=%h:%h exp=000000AA:000000BB", bus.hi_o, bus.lo_o); end

    set_slot(0, MTLO, 32'h11, 32'h0);
    set_slot(1, MTLO, 32'h22, 32'h0);
    step();
    idle_inputs();
    checks++; if (bus.lo_o !== 32'h22) begin failures++; $display("FAIL mt_same_reg got=%h exp=00000022", bus.lo_o); end

    set_slot(0, MTHI, 32'h77, 32'h0);
    bus.commit_kill = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.hi_o !== 32'hAA) begin failures++; $display("FAIL mt_killed got=%h exp=000000AA", bus.hi_o); end

    set_slot(0, MTLO, 32'h33, 32'h0);
    set_slot(1, MTLO, 32'h44, 32'h0);
    bus.flush[1] = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.lo_o !== 32'h33) begin failures++; $display("FAIL mt_flushed_slot got=%h exp=00000033", bus.lo_o); end
  endtask

  task automatic test_commit_kill_early();
    int lat, stalls; bit got; logic [31:0] mlo;
    bit lat_ok;
    load_hilo(32'h1, 32'h2);
    set_slot(0, DIVU, 32'd5, 32'd9);
    #1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      lat++;
      if (bus.done_o) got = 1'b1;
    end
    bus.req_op      = '0;
    bus.commit_kill = 1'b1;
    step();
    idle_inputs();
`ifdef MULDIV_EARLY_OUT_EN
    lat_ok = got && (lat <= 2);
`else
    lat_ok = got && (lat == DIV_LAT);
`endif
    checks++; if (!lat_ok) begin failures++; $display("FAIL early_latency got=%0d done=%b", lat, got); end
    checks++; if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'h2) begin
      failures++; $display("FAIL kill_at_done got=%h:%h exp=00000001:00000002", bus.hi_o, bus.lo_o); end

    set_slot(1, DIVU, 32'd5, 32'd9);
    run_op(lat, stalls, got, mlo);
    checks++; if (bus.lo_o !== 32'h0 || bus.hi_o !== 32'd5) begin
      failures++; $display("FAIL divu_small got=%h:%h exp=00000005:00000000", bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit got;
    idle_inputs();
    set_slot(1, MULTU, 32'd2, 32'd3);
    #1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      lat++;
      if (bus.done_o) got = 1'b1;
    end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL done_stall got=%b exp=0", bus.stall_o); end
    idle_inputs();
    set_slot(0, MTHI, 32'h55, 32'h0);
    step();
    idle_inputs();
    checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h6) begin
      failures++; $display("FAIL done_beats_mt got=%h:%h exp=00000000:00000006", bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_reset_mid();
    set_slot(0, MUL, 32'd3, 32'd3);
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++; $display("FAIL midreset_ctl got=%b%b exp=00", bus.stall_o, bus.done_o); end
    checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.mul_lo_o !== 32'h0) begin
      failures++; $display("FAIL midreset_regs got=%h:%h:%h exp=0:0:0", bus.hi_o, bus.lo_o, bus.mul_lo_o); end
    repeat (5) step();
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_select_mul();
    test_div();
    test_accumulate();
    test_flush();
    test_mthilo();
    test_commit_kill_early();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
